// File: rtl/sbio_mem_pkg.sv
// Shared command encodings and FSM state type for the serial-bus memory client.
package sbio_mem_pkg;

   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WADDR = 2'b10;
   localparam logic [1:0] CMD_WDATA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND_CMD,
      ST_SEND_WDATA
   } state_e;

endpackage

// File: rtl/sbio_mem_client_if.sv
// Request/response, transmitter and receiver signals of the memory client.
interface sbio_mem_client_if #(
   parameter int unsigned ADDR_BITS = 18,
   parameter int unsigned DATA_BITS = 16,
   parameter int unsigned TX_BITS   = 20,
   parameter int unsigned TAG_BITS  = 2
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_BITS-1:0] req_addr;
   logic [DATA_BITS-1:0] req_wdata;
   logic [TAG_BITS-1:0]  req_tag;

   logic                 rsp_valid;
   logic [DATA_BITS-1:0] rsp_data;
   logic [TAG_BITS-1:0]  rsp_tag;

   logic                 tx_ready;
   logic                 tx_payload_valid;
   logic [TX_BITS-1:0]   tx_payload;
   logic                 tx_payload_accepted;

   logic                 rx_payload_received;
   logic [DATA_BITS-1:0] rx_payload;

   // Environment side: user logic, transmitter and receiver
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_tag,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_tag,
      output tx_ready, tx_payload_accepted,
      input  tx_payload_valid, tx_payload,
      output rx_payload_received, rx_payload
   );

   // Client side
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_tag,
      output req_ready,
      output rsp_valid, rsp_data, rsp_tag,
      input  tx_ready, tx_payload_accepted,
      output tx_payload_valid, tx_payload,
      input  rx_payload_received, rx_payload
   );
endinterface

// File: rtl/sbio_tag_fifo.sv
// Read-tag FIFO: pop on empty is ignored, push and pop in one cycle both apply.
module sbio_tag_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_c_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int unsigned PTR_BITS = $clog2(DEPTH);
   localparam int unsigned CNT_BITS = $clog2(DEPTH+1);

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                do_push, do_pop;

   // Emptiness is judged before this cycle's push
   assign do_pop  = pop_i && !empty_q;
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      count_d = count_q + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
      full_d  = (count_d == CNT_BITS'(DEPTH));
      empty_d = (count_d == CNT_BITS'(0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_c_o = mem_q[rd_ptr_q];
   assign full_o   = full_q;
   assign empty_o  = empty_q;
   assign count_o  = count_q;

endmodule

// File: rtl/sbio_mem_client.sv
// Memory-request client: packs user requests into transmitter payloads and
// matches receiver payloads to outstanding reads in order.
module sbio_mem_client
   import sbio_mem_pkg::*;
#(
   parameter int unsigned IO_BITS           = 2,
   parameter int unsigned TX_PAYLOAD_CYCLES = 10,
   parameter int unsigned RX_PAYLOAD_CYCLES = 8,
   parameter int unsigned ADDR_BITS         = 18,
   parameter int unsigned TAG_BITS          = 2,
   parameter int unsigned MAX_OUTSTANDING   = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   sbio_mem_client_if.slave                       bus,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   error
);
   localparam int unsigned TX_BITS    = IO_BITS * TX_PAYLOAD_CYCLES;
   localparam int unsigned DATA_BITS  = IO_BITS * RX_PAYLOAD_CYCLES;
   localparam int unsigned FIELD_BITS = TX_BITS - 2;

   if (ADDR_BITS > FIELD_BITS) begin : g_bad_addr_bits
      $error("ADDR_BITS must not exceed TX_BITS-2");
   end
   if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_depth
      $error("MAX_OUTSTANDING must be a power of two >= 2");
   end

   state_e               state_q, state_d;
   logic [TX_BITS-1:0]   payload_q, payload_d;
   logic                 tx_valid_q, tx_valid_d;
   logic [TAG_BITS-1:0]  tag_q, tag_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;
   logic                 write_q, write_d;
   logic                 req_ready_c;
   logic                 fifo_push;

   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
   logic [TAG_BITS-1:0]  rsp_tag_q, rsp_tag_d;
   logic                 error_q, error_d;
   logic                 fifo_pop;
   logic [TAG_BITS-1:0]  fifo_head;
   logic                 fifo_full, fifo_empty;

   // Request FSM: next state, payload and tag capture
   always_comb begin
      state_d     = state_q;
      payload_d   = payload_q;
      tx_valid_d  = tx_valid_q;
      tag_d       = tag_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      req_ready_c = 1'b0;
      fifo_push   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready_c = !fifo_full;
            if (bus.req_valid && req_ready_c) begin
               payload_d  = {FIELD_BITS'(bus.req_addr),
                             bus.req_write ? CMD_WADDR : CMD_READ};
               tag_d      = bus.req_tag;
               wdata_d    = bus.req_wdata;
               write_d    = bus.req_write;
               tx_valid_d = 1'b1;
               state_d    = ST_SEND_CMD;
            end
         end
         ST_SEND_CMD: begin
            if (bus.tx_payload_accepted) begin
               if (write_q) begin
                  payload_d = {FIELD_BITS'(wdata_q), CMD_WDATA};
                  state_d   = ST_SEND_WDATA;
               end else begin
                  fifo_push  = 1'b1;
                  tx_valid_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_SEND_WDATA: begin
            if (bus.tx_payload_accepted) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         payload_q  <= '0;
         tx_valid_q <= 1'b0;
         tag_q      <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         payload_q  <= payload_d;
         tx_valid_q <= tx_valid_d;
         tag_q      <= tag_d;
         wdata_q    <= wdata_d;
         write_q    <= write_d;
      end
   end

   // Response path: in-order match of received payloads against read tags
   assign fifo_pop = bus.rx_payload_received && !fifo_empty;

   always_comb begin
      rsp_valid_d = fifo_pop;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      error_d     = error_q;
      if (fifo_pop) begin
         rsp_data_d = bus.rx_payload;
         rsp_tag_d  = fifo_head;
      end
      if (bus.rx_payload_received && fifo_empty) error_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         error_q     <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         error_q     <= error_d;
      end
   end

   sbio_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TAG_BITS)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_i   (fifo_push),
      .data_i   (tag_q),
      .pop_i    (fifo_pop),
      .head_c_o (fifo_head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .count_o  (outstanding)
   );

   assign bus.req_ready        = req_ready_c;
   assign bus.tx_payload_valid = tx_valid_q;
   assign bus.tx_payload       = payload_q;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_data         = rsp_data_q;
   assign bus.rsp_tag          = rsp_tag_q;
   assign error                = error_q;

   // The transmitter only takes a payload it is offered, and only while idle
   a_accept_offered: assert property (@(posedge clk) disable iff (reset)
      bus.tx_payload_accepted |-> (bus.tx_payload_valid && bus.tx_ready));

endmodule

// File: doc/sbio_mem_client.md
# sbio_mem_client

Memory-request client sitting between user logic and the serial-bus I/O pair: it packs read/write requests into transmitter payloads and matches incoming receiver payloads to outstanding reads. Downstream of user logic, it drives `sbio_transmitter` (payload handshake) and consumes `sbio_receiver` output (`payload_received`/`payload`). Reads are answered in order by the external RAM emulator; writes are posted and produce no response.

## Interface
Parameters:
- `IO_BITS`, 2: bits per bus cycle, shared with transmitter and receiver.
- `TX_PAYLOAD_CYCLES`, 10: transmitter payload cycles; `TX_BITS = IO_BITS*TX_PAYLOAD_CYCLES` (20).
- `RX_PAYLOAD_CYCLES`, 8: receiver payload cycles; `DATA_BITS = IO_BITS*RX_PAYLOAD_CYCLES` (16).
- `ADDR_BITS`, 18: address width; must be ≤ `TX_BITS-2`.
- `TAG_BITS`, 2: user tag width carried with each read.
- `MAX_OUTSTANDING`, 4: read tag FIFO depth (power of two, ≥ 2).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  client accepts a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_BITS  address.
- `req_wdata`  in  DATA_BITS  write data (ignored for reads).
- `req_tag`  in  TAG_BITS  tag returned with read response.
- `rsp_valid`  out  1  one-cycle pulse: read data valid; no backpressure.
- `rsp_data`  out  DATA_BITS  read data.
- `rsp_tag`  out  TAG_BITS  tag of the matching read.
- `tx_ready`  in  1  transmitter idle (informational only).
- `tx_payload_valid`  out  1  payload offered to transmitter.
- `tx_payload`  out  TX_BITS  payload to transmitter.
- `tx_payload_accepted`  in  1  transmitter took the payload this cycle.
- `rx_payload_received`  in  1  receiver message complete this cycle.
- `rx_payload`  in  DATA_BITS  received payload.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  reads in flight.
- `error`  out  1  sticky: response arrived with no outstanding read.

## Operation
- Payload layout (LSB sent first): `[1:0]` = cmd, `[TX_BITS-1:2]` = field, zero-extended. Cmds: `01` READ (field = addr), `10` WADDR (field = addr), `11` WDATA (field = wdata), `00` reserved, never sent.
- FSM states: IDLE, SEND_CMD, SEND_WDATA.
  - IDLE: `req_ready = (outstanding < MAX_OUTSTANDING)`. On `req_valid && req_ready`: register cmd payload and tag, capture wdata, go SEND_CMD.
  - SEND_CMD: `tx_payload_valid=1`, payload held stable. On `tx_payload_accepted`: read → push tag into FIFO, go IDLE; write → load WDATA payload, go SEND_WDATA.
  - SEND_WDATA: `tx_payload_valid=1`. On `tx_payload_accepted` → IDLE.
- `req_ready` is 0 outside IDLE; it is 0 in IDLE when the FIFO is full, for writes too.
- Response path: on `rx_payload_received` with FIFO non-empty, pop the tag; next cycle `rsp_valid=1`, `rsp_data=rx_payload` (registered), `rsp_tag=popped tag`.
- `rx_payload_received` with FIFO empty: no `rsp_valid`, `error` set to 1 until reset.
- A push and a pop in the same cycle both take effect; `outstanding` is unchanged. Emptiness for a pop is judged on the pre-push state, so a response that coincides with the first push is an error.
- `outstanding` equals FIFO occupancy and counts only reads accepted by the transmitter.
- `tx_ready` does not gate anything; the transmitter handshake alone governs. `tx_ready` is read only by an optional assertion.

## Timing
- Reset values: state IDLE, FIFO empty, `outstanding=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `tx_payload_valid=0`, `tx_payload=0`, `error=0`. `req_ready=1` in the first cycle after reset.
- Request accepted in cycle N → `tx_payload_valid=1` from N+1.
- Read accepted by the transmitter in cycle A → FIFO push visible at A+1; earliest next request accept is A+1.
- Write: WADDR accepted in cycle A → WDATA offered from A+1.
- `rsp_valid` latency: 1 cycle after `rx_payload_received`.
- Reset mid-message: client returns to IDLE and drops the pending payload and all tags. The system resets transmitter and receiver in the same cycle.

## Structure
- Package `sbio_mem_pkg`: cmd constants `CMD_READ`, `CMD_WADDR`, `CMD_WDATA`, and the FSM state enum.
- Sub-module `sbio_tag_fifo`: synchronous FIFO (depth `MAX_OUTSTANDING`, width `TAG_BITS`) with push/pop, full/empty and count outputs. Pop on empty is ignored, and simultaneous push/pop is defined as above.

## Test plan
- Read addr 0x1ABCD, tag 2 → `tx_payload=0x6AF35` held until accepted; `outstanding=1`; rx 0x1234 → next cycle `rsp_valid`, `rsp_data=0x1234`, `rsp_tag=2`, `outstanding=0`.
- Write addr 0x10, data 0xBEEF → payloads 0x00042 then 0x2FBBF, each held until accepted; no `rsp_valid`, `outstanding` stays 0.
- Four reads, tags 0..3, no responses → `req_ready=0` (a write is also blocked); one response → `rsp_tag=0`, `req_ready=1` again.
- Response in the same cycle as a read push with 1 outstanding → `rsp_valid` next cycle, `outstanding` stays 1.
- `rx_payload_received` with FIFO empty → `error=1` and stays 1; no `rsp_valid`; `reset` clears `error`.
- Reset asserted in SEND_WDATA → next cycle `tx_payload_valid=0`, `outstanding=0`, `req_ready=1`.
